jk_cmd_debounce: RTL

- Upstream command stage for the JK state-machine flip-flop.
- Takes two raw, bouncy, asynchronous command inputs (set and clear).
- Synchronises and debounces each input, then emits exactly one single-cycle `j` or `k` pulse per qualified press.
- `j`/`k` connect directly to the JK FSM's `j`/`k` inputs. Both blocks share `clk` and `reset`.

---
 rtl/jk_cmd_debounce.sv | 118 +++++++++++
 1 files changed

// File: rtl/jk_cmd_debounce.sv
// jk_cmd_debounce: command front end for the JK state-machine flip-flop.
// Two independent channels (set -> j/set_lvl, clr -> k/clr_lvl), each with
// a 2-FF synchroniser, an 8-bit qualification counter and a 4-state FSM.
// A level change is accepted only after DB_CYCLES consecutive identical
// synchronised samples. Each accepted press gives exactly one j/k pulse.
//
// Ports:
//   clk      - rising-edge clock shared with the downstream JK FSM
//   reset    - asynchronous, active-high reset
//   set_in   - raw, asynchronous, bouncy set command
//   clr_in   - raw, asynchronous, bouncy clear command
//   j        - one-cycle pulse on an accepted set press (registered)
//   k        - one-cycle pulse on an accepted clear press (registered)
//   set_lvl  - debounced level of set_in (registered)
//   clr_lvl  - debounced level of clr_in (registered)
//
// DB_CYCLES must lie in 2..255 so that DB_CYCLES-1 fits the 8-bit counter.

module jk_cmd_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic j,
    output logic k,
    output logic set_lvl,
    output logic clr_lvl
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_CH = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL_HI = 2'd1,
        PRESSED = 2'd2,
        QUAL_LO = 2'd3
    } db_state_e;

    // Channel 0 is set, channel 1 is clear.
    logic [NUM_CH-1:0] raw;
    assign raw = {clr_in, set_in};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        logic             pulse_q;
        logic             lvl_q;
        db_state_e        state_q;
        logic [CNT_W-1:0] cnt_q;

        // Synchroniser plus debounce FSM; only s2_q feeds the FSM.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                pulse_q <= 1'b0;
                lvl_q   <= 1'b0;
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                s1_q    <= raw[ch];
                s2_q    <= s1_q;
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (s2_q) begin
                            state_q <= QUAL_HI;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    QUAL_HI: begin
                        if (!s2_q) begin
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            // The only edge that ever raises the pulse.
                            state_q <= PRESSED;
                            pulse_q <= 1'b1;
                            lvl_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s2_q) begin
                            state_q <= QUAL_LO;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    QUAL_LO: begin
                        if (s2_q) begin
                            // Release bounce: return without a new pulse.
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            lvl_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        lvl_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign j       = g_ch[0].pulse_q;
    assign set_lvl = g_ch[0].lvl_q;
    assign k       = g_ch[1].pulse_q;
    assign clr_lvl = g_ch[1].lvl_q;

endmodule
